uart_tx_buffered: RTL
=====================

Name: uart_tx_buffered

Overview:
- Transmit-side counterpart to the UART receive path. Takes bytes from an internal producer, such as a register readback or status reporter, and buffers them in a small FIFO.
- Serialises each byte as 8N1 (configurable stop bits) on the serial line, paced by the shared baud clock-enable from the clock wizard.
- Sits between the memory/controller side and the tx_data pin.

Parameters:
- FIFO_DEPTH, 4, number of byte entries buffered; power of two, minimum 2.
- DATA_BITS, 8, payload bits per frame.
- STOP_BITS, 1, stop-bit periods per frame; 1 or 2.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_en  input  1  baud tick; one clk_in-cycle pulse per bit period.
- data_in  input  DATA_BITS  byte to transmit.
- data_valid  input  1  data_in is offered this cycle.
- ready  output  1  FIFO can accept a byte; high when count != FIFO_DEPTH.
- tx_data  output  1  serial line; idle high.
- busy  output  1  frame in progress, or FIFO non-empty.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when data_valid is high while ready is low.

Behaviour:
- Interface decision: one clock (clk_in). Reset is synchronous and active-high (reset).
- Reset state:
  - tx_data=1, ready=1, busy=0, fifo_count=0, overflow=0.
  - FIFO flushed; FSM returns to IDLE.
  - Reset mid-frame aborts the frame: line high at the edge after reset; no partial frame resumes.
- Push rule:
  - Push occurs on a rising edge where data_valid && ready.
  - ready derives from the registered count only. When full, a push is rejected even if a pop happens in the same cycle.
  - A rejected push sets overflow, which stays set until reset.
- Pop: the FSM pops one entry at the moment it loads the shift register.
- Simultaneous push and pop: both happen; fifo_count is unchanged.
- FIFO ordering: strict FIFO, pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_data=1. On clk_en with FIFO non-empty: pop into the shift register, drive tx_data=0, go to START.
  - START: on clk_en, drive bit 0 (LSB first), bit index = 0, go to DATA.
  - DATA: on each clk_en, shift right and advance the index. After bit DATA_BITS-1 has been held one tick, drive tx_data=1 and go to STOP.
  - STOP: hold 1 for STOP_BITS ticks. On the final tick:
    - FIFO non-empty: pop, drive 0, go to START (back-to-back, no idle gap).
    - Otherwise go to IDLE.
- Bit-period rule: every bit, including start and stop, is held exactly one clk_en period. Frame = 1 + DATA_BITS + STOP_BITS ticks.
- Output timing: tx_data is registered and changes only on the clk_in edge where clk_en=1 (or on reset). Glitch-free.
- Latency: a byte pushed into an empty FIFO while IDLE has its start bit appear on the first clk_en at least one cycle after the push edge.
- clk_en held high continuously: each clk_in cycle is treated as a bit period. This is legal and is used in simulation.
- busy = (state != IDLE) || (fifo_count != 0).

Decomposition:
- Shared package uart_pkg:
  - FSM state enum uart_state_t (IDLE, START, DATA, STOP).
  - Constants UART_IDLE_LEVEL=1, UART_START_LEVEL=0.
  - Default DATA_BITS/STOP_BITS, so the receiver and transmitter agree on the frame format.
- One sub-module: sync_fifo (parameterised width and depth).
  - Ports: push, pop, din, dout, count, full, empty.
  - Reusable later on the receive side.

Test Plan:
- Single byte: reset, then push 0xA5 with clk_en every 16 clocks. Line reads 0,1,0,1,0,0,1,0,1,1 per tick: start, LSB-first data, stop. busy drops after the stop tick.
- Back-to-back: push 0x00, 0xFF, 0x3C in consecutive cycles. Three contiguous 10-tick frames with no idle tick between them. fifo_count goes 1,2,3, then decrements at each start bit.
- Full/overflow (FIFO_DEPTH=4, clk_en held low): push 5 bytes. The 5th is rejected, ready=0, overflow=1. Enabling ticks transmits exactly the first 4 bytes, in order.
- Push and pop in the same cycle: FIFO holds 2 entries. Push coincides with the stop-tick pop. fifo_count stays 2 and data order is preserved.
- Reset mid-frame: assert reset during data bit 3 of 0x81. tx_data=1 the next edge, fifo_count=0, and no further frame bits appear after reset is released.
- STOP_BITS=2 with continuous clk_en: push 0x55. Frame is 11 cycles wide with two high stop bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Frame-format constants and FSM state type shared by the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come from the count register only.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage, pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW + 1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == (AW + 1)'(DEPTH));
    assign empty = (r_count == {(AW + 1){1'b0}});

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a small FIFO and are shifted out LSB first on baud ticks.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int STOP_BITS  = UART_STOP_BITS
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          clk_en,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          data_valid,
    output logic                          ready,
    output logic                          tx_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_nxt;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_overflow;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_fifo_dout;
    logic [CW-1:0]        w_fifo_count;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .reset  (reset),
        .push   (data_valid),
        .pop    (w_pop),
        .din    (data_in),
        .dout   (w_fifo_dout),
        .count  (w_fifo_count),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty)
    );

    // FSM and datapath registers; reset forces the line idle and abandons any frame.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shift    <= {DATA_BITS{1'b0}};
            r_idx      <= {IW{1'b0}};
            r_stop_cnt <= 1'b0;
            r_tx       <= UART_IDLE_LEVEL;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_idx      <= w_idx_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Next-state logic; every transition waits for a baud tick so tx_data only moves on ticks.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_idx_nxt      = r_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_tx_nxt       = r_tx;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                if (clk_en && !w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_tx_nxt    = UART_START_LEVEL;
                    w_state_nxt = START;
                end else begin
                    w_tx_nxt = UART_IDLE_LEVEL;
                end
            end
            START: begin
                if (clk_en) begin
                    w_tx_nxt    = r_shift[0];
                    w_idx_nxt   = {IW{1'b0}};
                    w_state_nxt = DATA;
                end else begin
                    w_state_nxt = START;
                end
            end
            DATA: begin
                if (clk_en && (r_idx == LAST_BIT)) begin
                    w_tx_nxt       = UART_IDLE_LEVEL;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = STOP;
                end else if (clk_en) begin
                    w_shift_nxt = r_shift >> 1;
                    w_tx_nxt    = r_shift[1];
                    w_idx_nxt   = r_idx + IW'(1);
                end else begin
                    w_state_nxt = DATA;
                end
            end
            STOP: begin
                if (clk_en && (r_stop_cnt == LAST_STOP)) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_tx_nxt    = UART_START_LEVEL;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (clk_en) begin
                    w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = UART_IDLE_LEVEL;
            end
        endcase
    end

    // Sticky record of any byte offered while the buffer was full.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (data_valid && w_fifo_full) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign ready      = !w_fifo_full;
    assign tx_data    = r_tx;
    assign busy       = (r_state != IDLE) || (w_fifo_count != CW'(0));
    assign fifo_count = w_fifo_count;
    assign overflow   = r_overflow;

endmodule
